// File: rtl/bank_pkg.sv
// Shared types and widths for the bank queue front-end (door FSM states, count limits).
package bank_pkg;

  localparam int unsigned PCOUNT_W   = 3;
  localparam int unsigned TCOUNT_W   = 2;
  localparam int unsigned PCOUNT_MAX = 7;
  localparam int unsigned TCOUNT_MIN = 1;
  localparam int unsigned TCOUNT_MAX = 3;

  typedef enum logic [2:0] {
    IDLE,
    A1,
    AB_IN,
    B_IN,
    B1,
    AB_OUT,
    A_OUT,
    CLEAR
  } q_state_t;

endpackage

// File: rtl/queue_counter_sync2.sv
// Two-flop synchroniser for one asynchronous sensor level.
module sync2 (
  input  logic clk,
  input  logic rst,
  input  logic i_d,
  output logic o_q
);

  logic r_meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_meta <= 1'b0;
      o_q    <= 1'b0;
    end else begin
      r_meta <= i_d;
      o_q    <= r_meta;
    end
  end

endmodule

// File: rtl/queue_counter.sv
// Door-sensor direction FSM with saturating queue and teller counters.
// Optional QCNT_REJECT_STATS_EN adds a count of entries arriving while the queue is full.
module queue_counter
  import bank_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 1000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                sensor_a,
  input  logic                sensor_b,
  input  logic                teller_inc,
  input  logic                teller_dec,
  output logic [PCOUNT_W-1:0] pcount,
  output logic [TCOUNT_W-1:0] tcount,
  output logic                full,
  output logic                empty,
  output logic                entry_pulse,
  output logic                exit_pulse
`ifdef QCNT_REJECT_STATS_EN
  ,
  output logic [7:0]          reject_cnt,
  output logic                reject_pulse
`endif
);

  localparam int unsigned TW = $clog2(TIMEOUT_CYC);

  logic                w_sa;
  logic                w_sb;
  q_state_t            r_state;
  q_state_t            w_state_nxt;
  logic [TW-1:0]       r_timer;
  logic                w_timeout;
  logic                w_entry;
  logic                w_exit;
  logic [PCOUNT_W-1:0] w_pcount_nxt;
  logic [TCOUNT_W-1:0] w_tcount_nxt;

  sync2 u_sync_a (.clk(clk), .rst(rst), .i_d(sensor_a), .o_q(w_sa));
  sync2 u_sync_b (.clk(clk), .rst(rst), .i_d(sensor_b), .o_q(w_sb));

  // Next state; a stalled partial passage is dumped into CLEAR regardless of inputs.
  always_comb begin
    w_state_nxt = r_state;
    w_entry     = 1'b0;
    w_exit      = 1'b0;
    w_timeout   = (r_state != IDLE) && (r_timer == TW'(TIMEOUT_CYC - 1));
    if (w_timeout) begin
      w_state_nxt = CLEAR;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_sa && !w_sb)      w_state_nxt = A1;
          else if (!w_sa && w_sb) w_state_nxt = B1;
          else if (w_sa && w_sb)  w_state_nxt = CLEAR;
        end
        A1: begin
          if (w_sa && w_sb)        w_state_nxt = AB_IN;
          else if (!w_sa && !w_sb) w_state_nxt = IDLE;
        end
        AB_IN: begin
          if (!w_sa && w_sb)      w_state_nxt = B_IN;
          else if (w_sa && !w_sb) w_state_nxt = A1;
        end
        B_IN: begin
          if (!w_sa && !w_sb) begin
            w_state_nxt = IDLE;
            w_entry     = 1'b1;
          end else if (w_sa && w_sb) begin
            w_state_nxt = AB_IN;
          end
        end
        B1: begin
          if (w_sa && w_sb)        w_state_nxt = AB_OUT;
          else if (!w_sa && !w_sb) w_state_nxt = IDLE;
        end
        AB_OUT: begin
          if (w_sa && !w_sb)      w_state_nxt = A_OUT;
          else if (!w_sa && w_sb) w_state_nxt = B1;
        end
        A_OUT: begin
          if (!w_sa && !w_sb) begin
            w_state_nxt = IDLE;
            w_exit      = 1'b1;
          end else if (w_sa && w_sb) begin
            w_state_nxt = AB_OUT;
          end
        end
        CLEAR: begin
          if (!w_sa && !w_sb) w_state_nxt = IDLE;
        end
        default: w_state_nxt = IDLE;
      endcase
    end
  end

  // State register and dwell timer; the timer restarts on every state change.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_timer <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE || w_state_nxt != r_state || w_timeout) r_timer <= '0;
      else                                                        r_timer <= r_timer + TW'(1);
    end
  end

  always_comb begin
    w_pcount_nxt = pcount;
    if (w_entry && pcount != PCOUNT_W'(PCOUNT_MAX)) w_pcount_nxt = pcount + PCOUNT_W'(1);
    else if (w_exit && pcount != '0)                w_pcount_nxt = pcount - PCOUNT_W'(1);
  end

  // Simultaneous open/close requests cancel.
  always_comb begin
    w_tcount_nxt = tcount;
    if (teller_inc && !teller_dec && tcount != TCOUNT_W'(TCOUNT_MAX))
      w_tcount_nxt = tcount + TCOUNT_W'(1);
    else if (teller_dec && !teller_inc && tcount != TCOUNT_W'(TCOUNT_MIN))
      w_tcount_nxt = tcount - TCOUNT_W'(1);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pcount      <= '0;
      tcount      <= TCOUNT_W'(TCOUNT_MIN);
      full        <= 1'b0;
      empty       <= 1'b1;
      entry_pulse <= 1'b0;
      exit_pulse  <= 1'b0;
    end else begin
      pcount      <= w_pcount_nxt;
      tcount      <= w_tcount_nxt;
      full        <= (w_pcount_nxt == PCOUNT_W'(PCOUNT_MAX));
      empty       <= (w_pcount_nxt == '0);
      entry_pulse <= w_entry;
      exit_pulse  <= w_exit && (pcount != '0);
    end
  end

`ifdef QCNT_REJECT_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      reject_cnt   <= '0;
      reject_pulse <= 1'b0;
    end else begin
      reject_pulse <= w_entry && (pcount == PCOUNT_W'(PCOUNT_MAX));
      if (w_entry && pcount == PCOUNT_W'(PCOUNT_MAX) && reject_cnt != 8'hFF)
        reject_cnt <= reject_cnt + 8'd1;
    end
  end
`endif

endmodule

// File: tb/tb_queue_counter.sv
// Self-checking bench for queue_counter: passage-position reference model plus directed literals.
module tb_queue_counter;

  localparam int TO = 64;
  localparam int D_IDLE = 0, D_IN = 1, D_OUT = 2, D_CLR = 3;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       sensor_a = 1'b0, sensor_b = 1'b0;
  logic       teller_inc = 1'b0, teller_dec = 1'b0;
  logic [2:0] pcount;
  logic [1:0] tcount;
  logic       full, empty, entry_pulse, exit_pulse;
`ifdef QCNT_REJECT_STATS_EN
  logic [7:0] reject_cnt;
  logic       reject_pulse;
`endif

  queue_counter #(.TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst(rst), .sensor_a(sensor_a), .sensor_b(sensor_b),
    .teller_inc(teller_inc), .teller_dec(teller_dec),
    .pcount(pcount), .tcount(tcount), .full(full), .empty(empty),
    .entry_pulse(entry_pulse), .exit_pulse(exit_pulse)
`ifdef QCNT_REJECT_STATS_EN
    , .reject_cnt(reject_cnt), .reject_pulse(reject_pulse)
`endif
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;
  bit chk_en   = 1'b0;
  bit rnd_tel  = 1'b0;
  int n_entp   = 0;
  int n_extp   = 0;

  task automatic chk(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s got %0d want %0d at %0t", name, got, exp, $time);
  endtask

  // Reference model: a passage is a direction plus a depth 0..3 through the door;
  // depth may only move by one step, and walking off the far side counts.
  int m_p = 0, m_t = 1, m_dir = D_IDLE, m_pos = 0, m_tm = 0, m_rej = 0;
  bit m_ent = 0, m_ext = 0, m_rejp = 0;
  bit m_sa1 = 0, m_sa2 = 0, m_sb1 = 0, m_sb2 = 0;

  function automatic int pos_of(int dir, bit a, bit b);
    if (!a && !b) return 0;
    if (a && b)   return 2;
    if (dir == D_IN) return a ? 1 : 3;
    return b ? 1 : 3;
  endfunction

  always @(posedge clk) begin
    int od, op, np;
    bit sa, sb, tmo;
    if (rst) begin
      m_p = 0; m_t = 1; m_dir = D_IDLE; m_pos = 0; m_tm = 0; m_rej = 0;
      m_ent = 0; m_ext = 0; m_rejp = 0;
      m_sa1 = 0; m_sa2 = 0; m_sb1 = 0; m_sb2 = 0;
    end else begin
      m_ent = 0; m_ext = 0; m_rejp = 0;
      sa = m_sa2; sb = m_sb2; od = m_dir; op = m_pos; tmo = 0;
      if (m_dir != D_IDLE && m_tm == TO - 1) begin
        m_dir = D_CLR; m_pos = 0; tmo = 1;
      end else if (m_dir == D_IDLE) begin
        if (sa && !sb)      begin m_dir = D_IN;  m_pos = 1; end
        else if (!sa && sb) begin m_dir = D_OUT; m_pos = 1; end
        else if (sa && sb)  m_dir = D_CLR;
      end else if (m_dir == D_CLR) begin
        if (!sa && !sb) m_dir = D_IDLE;
      end else begin
        np = pos_of(m_dir, sa, sb);
        if (m_pos == 3 && np == 0) begin
          if (m_dir == D_IN) begin
            m_ent = 1;
            if (m_p == 7) begin m_rejp = 1; if (m_rej < 255) m_rej++; end
            else m_p++;
          end else if (m_p > 0) begin
            m_ext = 1; m_p--;
          end
          m_dir = D_IDLE; m_pos = 0;
        end else if (np == m_pos + 1 || np + 1 == m_pos) begin
          m_pos = np;
          if (np == 0) m_dir = D_IDLE;
        end
      end
      if (tmo || od == D_IDLE || m_dir != od || m_pos != op) m_tm = 0;
      else m_tm++;
      m_sa2 = m_sa1; m_sa1 = sensor_a;
      m_sb2 = m_sb1; m_sb1 = sensor_b;
      if (teller_inc && !teller_dec && m_t < 3)      m_t++;
      else if (teller_dec && !teller_inc && m_t > 1) m_t--;
    end
  end

  always @(negedge clk) begin
    if (entry_pulse) n_entp++;
    if (exit_pulse)  n_extp++;
    if (chk_en) begin
      chk("pcount", pcount, m_p);
      chk("tcount", tcount, m_t);
      chk("full", full, (m_p == 7) ? 1 : 0);
      chk("empty", empty, (m_p == 0) ? 1 : 0);
      chk("entry_pulse", entry_pulse, m_ent);
      chk("exit_pulse", exit_pulse, m_ext);
`ifdef QCNT_REJECT_STATS_EN
      chk("reject_cnt", reject_cnt, m_rej);
      chk("reject_pulse", reject_pulse, m_rejp);
`endif
    end
  end

  task automatic hold(input bit a, input bit b, input int n);
    sensor_a = a; sensor_b = b;
    repeat (n) begin
      @(posedge clk); #1;
      if (rnd_tel) begin
        teller_inc = ($urandom_range(0, 7) == 0);
        teller_dec = ($urandom_range(0, 7) == 0);
      end
    end
  endtask

  task automatic do_entry();
    hold(1, 0, 4); hold(1, 1, 4); hold(0, 1, 4); hold(0, 0, 6);
  endtask

  task automatic do_exit();
    hold(0, 1, 4); hold(1, 1, 4); hold(1, 0, 4); hold(0, 0, 6);
  endtask

  task automatic pulse_rst();
    rst = 1'b1; @(posedge clk); #1; rst = 1'b0;
  endtask

  task automatic tel(input bit inc, input bit dec, input int exp, input string name);
    teller_inc = inc; teller_dec = dec;
    @(posedge clk); #1;
    teller_inc = 1'b0; teller_dec = 1'b0;
    @(negedge clk); chk(name, tcount, exp);
    @(posedge clk); #1;
  endtask

  initial begin
    int e0, x0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    hold(0, 0, 5);
    @(negedge clk);
    chk_en = 1'b1;
    chk("rst_pcount", pcount, 0);
    chk("rst_tcount", tcount, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_pulses", {entry_pulse, exit_pulse}, 0);
    @(posedge clk); #1;

    // Entry with the pulse landing exactly three edges after the last fall.
    hold(1, 0, 10); hold(1, 1, 10); hold(0, 1, 10);
    sensor_b = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); chk("entry_lat_early", entry_pulse, 0);
    @(negedge clk); chk("entry_lat", entry_pulse, 1);
    chk("entry_pcount", pcount, 1);
    chk("entry_empty", empty, 0);
    @(negedge clk); chk("entry_once", entry_pulse, 0);
    @(posedge clk); #1;

    x0 = n_extp; do_exit();
    chk("exit_1to0", pcount, 0); chk("exit_1to0_pulse", n_extp - x0, 1);
    x0 = n_extp; do_exit();
    chk("exit_empty", pcount, 0); chk("exit_empty_pulse", n_extp - x0, 0);
    do_entry(); do_entry(); do_exit();
    chk("exit_2to1", pcount, 1);

    hold(1, 0, 5); hold(1, 1, 5); hold(1, 0, 5); hold(0, 0, 6);
    chk("backout", pcount, 1);

    hold(1, 0, TO + 5); hold(1, 1, 5); hold(0, 1, 5); hold(0, 0, 6);
    chk("timeout_nocount", pcount, 1);
    do_entry();
    chk("after_timeout", pcount, 2);

    pulse_rst();
    hold(0, 0, 3);
    for (int i = 1; i <= 9; i++) begin
      e0 = n_entp;
      do_entry();
      if (i == 7) begin chk("sat_full", full, 1); chk("sat_p7", pcount, 7); end
`ifdef QCNT_REJECT_STATS_EN
      if (i == 8) chk("reject_first", reject_cnt, 1);
`endif
      if (i == 9) begin chk("sat_pulse", n_entp - e0, 1); chk("sat_hold", pcount, 7); end
    end

    tel(1, 0, 2, "inc1"); tel(1, 0, 3, "inc2"); tel(1, 0, 3, "inc3"); tel(1, 0, 3, "inc4");
    tel(1, 1, 3, "inc_dec");
    tel(0, 1, 2, "dec1"); tel(0, 1, 1, "dec2"); tel(0, 1, 1, "dec3");
    tel(0, 1, 1, "dec4"); tel(0, 1, 1, "dec5");
    tel(1, 0, 2, "inc_pre_rst");

    hold(1, 0, 5); hold(1, 1, 5);
    pulse_rst();
    @(negedge clk);
    chk("midrst_pcount", pcount, 0); chk("midrst_tcount", tcount, 1);
    @(posedge clk); #1;
    hold(0, 0, 6); do_entry();
    chk("post_rst_entry", pcount, 1);

    rnd_tel = 1'b1;
    for (int k = 0; k < 400; k++) begin
      int r;
      r = $urandom_range(0, 9);
      if (r < 4)       hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(1, 12));
      else if (r < 6)  do_entry();
      else if (r < 8)  do_exit();
      else if (r == 8) hold(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(50, 80));
      else             hold(0, 0, $urandom_range(1, 8));
      if ($urandom_range(0, 99) == 0) pulse_rst();
    end
    rnd_tel = 1'b0; teller_inc = 1'b0; teller_dec = 1'b0;
    hold(0, 0, 5);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
